// File: rtl/console_slave_regs.sv
// ---------------------------------------------------------------------------
// console_slave_regs
//
// Slave-side register responder for the 8-bit console bus. The host reads
// status, drains engine output bytes from an RX FIFO and writes connection
// commands that are handed to the FIX engine over a valid/ready handshake.
//
// Register map (slave_address[7:3] must be zero, otherwise the access is
// ignored):
//   0x00 RSTAT (R)  {2'b0, cmd_drop, underflow, full, overflow, cmd_valid,
//                    non_empty}. The read clears the three sticky bits.
//   0x01 RDATA (R)  FIFO head, popped by the read. An empty FIFO returns 0x00
//                   and raises underflow.
//   0x02 LEVEL (R)  FIFO occupancy, 0..FIFO_DEPTH.
//   0x06 CONN  (W)  loads cmd_data and raises cmd_valid.
//
// Ports:
//   clk              single clock, rising edge
//   reset            asynchronous, active-low, clears all state
//   slave_address    register address
//   slave_read       read strobe
//   slave_readdata   registered read data, 1 clock latency
//   slave_write      write strobe
//   slave_writedata  write data
//   cmd_valid        command byte pending toward the engine
//   cmd_data         command byte
//   cmd_ready        engine accepts the command
//   rx_valid         engine output byte offered
//   rx_data          engine output byte
//   rx_ready         FIFO not full
//
// FIFO_DEPTH must be a power of two between 2 and 128 so the level fits in
// the 8-bit LEVEL register.
// ---------------------------------------------------------------------------
module console_slave_regs #(
  parameter int FIFO_DEPTH = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] slave_address,
  input  logic       slave_read,
  output logic [7:0] slave_readdata,
  input  logic       slave_write,
  input  logic [7:0] slave_writedata,
  output logic       cmd_valid,
  output logic [7:0] cmd_data,
  input  logic       cmd_ready,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] ADDR_RSTAT = 3'd0;
  localparam logic [2:0] ADDR_RDATA = 3'd1;
  localparam logic [2:0] ADDR_LEVEL = 3'd2;
  localparam logic [2:0] ADDR_CONN  = 3'd6;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  logic        overflow;
  logic        underflow;
  logic        cmd_drop;

  logic        addr_ok;
  logic        rd_access;
  logic        wr_access;
  logic        fifo_empty;
  logic        fifo_full;
  logic [7:0]  level;
  logic [7:0]  head;
  logic [7:0]  rstat;
  logic [7:0]  rd_value;

  logic        push;
  logic        pop;
  logic        rstat_rd;
  logic        overflow_set;
  logic        underflow_set;
  logic        conn_wr;
  logic        handshake;

  // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
  // that differ only in the wrap bit mean full.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level      = 8'(wr_ptr - rd_ptr);
  assign head       = mem[rd_ptr[AW-1:0]];
  assign rx_ready   = !fifo_full;

  assign addr_ok    = (slave_address[7:3] == 5'd0);
  assign rd_access  = slave_read  && addr_ok;
  assign wr_access  = slave_write && addr_ok;

  assign rstat_rd      = rd_access && (slave_address[2:0] == ADDR_RSTAT);
  assign pop           = rd_access && (slave_address[2:0] == ADDR_RDATA) && !fifo_empty;
  assign underflow_set = rd_access && (slave_address[2:0] == ADDR_RDATA) && fifo_empty;
  assign push          = rx_valid && !fifo_full;
  assign overflow_set  = rx_valid && fifo_full;

  assign conn_wr   = wr_access && (slave_address[2:0] == ADDR_CONN);
  assign handshake = cmd_valid && cmd_ready;

  assign rstat = {2'b00, cmd_drop, underflow, fifo_full, overflow, cmd_valid, !fifo_empty};

  // Read mux. The status snapshot is taken before this edge's sticky
  // clears and sets, so the host sees the bits it is about to clear.
  always_comb begin
    rd_value = 8'h00;
    case (slave_address[2:0])
      ADDR_RSTAT: rd_value = rstat;
      ADDR_RDATA: rd_value = fifo_empty ? 8'h00 : head;
      ADDR_LEVEL: rd_value = level;
      default:    rd_value = 8'h00;
    endcase
  end

  // Read data register: only a decoded read updates it, so the value holds
  // between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slave_readdata <= 8'h00;
    end else if (rd_access) begin
      slave_readdata <= rd_value;
    end
  end

  // FIFO storage has no reset; the pointers alone define which entries are
  // live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky status bits: a set on the same edge as an RSTAT read wins over
  // the clear so no event is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      cmd_drop  <= 1'b0;
    end else begin
      if (overflow_set)  overflow <= 1'b1;
      else if (rstat_rd) overflow <= 1'b0;

      if (underflow_set) underflow <= 1'b1;
      else if (rstat_rd) underflow <= 1'b0;

      if (conn_wr && cmd_valid && !cmd_ready) cmd_drop <= 1'b1;
      else if (rstat_rd)                      cmd_drop <= 1'b0;
    end
  end

  // Command holding register. A CONN write is accepted when the slot is
  // free or is being emptied by a handshake on this same edge; otherwise
  // the pending command is preserved and the new byte is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_valid <= 1'b0;
      cmd_data  <= 8'h00;
    end else if (conn_wr && (!cmd_valid || handshake)) begin
      cmd_valid <= 1'b1;
      cmd_data  <= slave_writedata;
    end else if (handshake) begin
      cmd_valid <= 1'b0;
    end
  end

endmodule

// File: doc/console_slave_regs.md
# console_slave_regs

Slave-side register responder for the 8-bit console bus driven by the host (testbench or CPU bridge): decodes `slave_address`/`slave_read`/`slave_write`, forwards connection commands written to CONN into the FIX engine over a valid/ready handshake, and buffers engine output bytes in a FIFO that the host drains through RSTAT/RDATA. It sits between the host bus and the FIX engine core.

## Interface
- `FIFO_DEPTH`, 128, RX byte FIFO depth; power of 2, 2..128, so the level fits in 8 bits.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `slave_address`  in  8  register address; only bits [2:0] decoded, bits [7:3] must be 0 or access is ignored.
- `slave_read`  in  1  read strobe, sampled on rising `clk`.
- `slave_readdata`  out  8  registered read data.
- `slave_write`  in  1  write strobe, sampled on rising `clk`.
- `slave_writedata`  in  8  write data.
- `cmd_valid`  out  1  command byte pending toward the engine.
- `cmd_data`  out  8  command byte.
- `cmd_ready`  in  1  engine accepts the command.
- `rx_valid`  in  1  engine output byte offered.
- `rx_data`  in  8  engine output byte.
- `rx_ready`  out  1  equals FIFO not full; combinational from registered state.

## Operation
- Register map:
  - 0x00 RSTAT (R): bit0 FIFO non-empty, bit1 `cmd_valid`, bit2 overflow (sticky), bit3 FIFO full, bit4 underflow (sticky), bit5 cmd_drop (sticky), bits 7:6 = 0. A read clears bits 2, 4 and 5 after returning them.
  - 0x01 RDATA (R): returns the FIFO head and pops it. If the FIFO is empty, returns 0x00, sets underflow and does not pop.
  - 0x02 LEVEL (R): current FIFO occupancy, 0..FIFO_DEPTH.
  - 0x06 CONN (W): loads `cmd_data` and sets `cmd_valid`.
  - All other addresses read 0x00. Writes to them, and writes to read-only registers, are ignored.
- Command path:
  - `cmd_valid` sets on the edge after a CONN write. It holds with `cmd_data` stable until an edge where `cmd_valid && cmd_ready`, then clears.
  - CONN write while `cmd_valid=1` and `cmd_ready=0`: the write is dropped, cmd_drop is set, and `cmd_data` is unchanged.
  - CONN write on the same edge the handshake completes: the new byte loads and `cmd_valid` stays 1.
- RX path:
  - A push occurs on an edge where `rx_valid && rx_ready`.
  - `rx_valid` while full: no push, overflow is set, and the engine is expected to hold the byte.
- Simultaneous events:
  - Push and pop on the same edge when the FIFO is non-empty: both take effect and the level is unchanged.
  - Pop on an empty FIFO with a simultaneous push: underflow, read returns 0x00, and the pushed byte is stored (level becomes 1).
  - Push with RSTAT read clearing overflow on the same edge: the set wins.
  - `slave_read` and `slave_write` in the same cycle: both honored.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2·FIFO_DEPTH. Full and empty are detected by MSB compare.

## Timing
- Reset (async assert, sync-safe deassert) forces:
  - `slave_readdata`=0x00, `cmd_valid`=0, `cmd_data`=0x00.
  - FIFO empty, level 0.
  - All sticky bits cleared.
  - `rx_ready`=1.
- Reset mid-operation discards FIFO contents and any pending command. No handshake completes on the reset edge.
- Read latency is 1 clock: `slave_readdata` updates on the edge that samples `slave_read` and holds until the next sampled read. It is valid from that edge onward, so a strobe shorter than one period still works if it spans a rising edge.
- Pop and sticky-clear take effect on the same sampling edge, so a back-to-back RDATA read on the next edge returns the next byte.
- `cmd_valid` rises 1 clock after the CONN write edge. Minimum throughput is one command every 2 clocks with `cmd_ready` tied high.
- `rx_ready` drops in the same cycle the FIFO becomes full.

## Test plan
- Reset, then read RSTAT, LEVEL and RDATA → 0x00, 0x00, 0x00. A second RSTAT read shows bit4 set, then 0x00 on the following read.
- CONN write 0xbb with `cmd_ready`=0 for 5 cycles → `cmd_valid`=1 and `cmd_data`=0xbb held. Write 0xcc → dropped, RSTAT=0x22. Raise `cmd_ready` → `cmd_valid` clears 1 clock later.
- Push 198 bytes 0x00..0xC5 with `FIFO_DEPTH`=256 is illegal; use 128 instead. Push 0x00..0x7F → LEVEL=0x80, RSTAT bit3=1, `rx_ready`=0. A further `rx_valid` sets bit2. 128 RDATA reads return 0x00..0x7F in order.
- Pointer wrap: repeat push 100 / pop 100 three times → data intact and LEVEL returns to 0 each round.
- Simultaneous push of 0x55 with an RDATA read on an empty FIFO → readdata 0x00, underflow set, LEVEL=1, next RDATA returns 0x55.
- Assert `reset` low mid-burst with LEVEL=40 and `cmd_valid`=1 → all outputs return to their reset values immediately, and LEVEL reads 0 after release.
